// File: rtl/mux_n_to_1_seq_if.sv
// mux_n_to_1_seq_if
//   Bundles the data, control and status signals of mux_n_to_1_seq.
//   master : the traffic source. It drives d, mode, s, en, start and hold,
//            and observes y, valid, busy, done and dbg_state.
//   slave  : the multiplexer. It has the opposite directions.
//   d      : packed input channels. Channel k sits at [k*DATA_WIDTH +: DATA_WIDTH].
//   mode   : 0 = direct select, 1 = scan (parallel-to-serial).
//   s / en : direct-mode channel select and sample strobe.
//   start  : scan-mode capture-and-scan request.
//   hold   : scan-mode stall, driven high while downstream is not ready.
//   y      : registered output data.
//   valid  : y carries a new sample this cycle.
//   busy   : high while the block is in the SCAN state.
//   done   : one-cycle pulse that coincides with the last scanned sample.
//   dbg_state : FSM state for observation. 0 = IDLE, 1 = SCAN.
interface mux_n_to_1_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 8,
  parameter int SEL_WIDTH  = 3
);
  logic [NUM_INPUTS*DATA_WIDTH-1:0] d;
  logic                             mode;
  logic [SEL_WIDTH-1:0]             s;
  logic                             en;
  logic                             start;
  logic                             hold;
  logic [DATA_WIDTH-1:0]            y;
  logic                             valid;
  logic                             busy;
  logic                             done;
  logic                             dbg_state;

  modport master (
    output d, mode, s, en, start, hold,
    input  y, valid, busy, done, dbg_state
  );

  modport slave (
    input  d, mode, s, en, start, hold,
    output y, valid, busy, done, dbg_state
  );
endinterface

// File: rtl/mux_n_to_1_seq.sv
// mux_n_to_1_seq
//   An N-to-1 multiplexer with a registered output and two operating modes.
//   Direct mode: when en is high, the selected channel s is registered onto y
//     one cycle later.
//   Scan mode: a start request captures every channel into an internal bank.
//     The bank is then emitted one channel per unstalled cycle, in order from
//     channel 0 to channel NUM_INPUTS-1.
//   Ports:
//     clk : rising-edge clock.
//     rst : asynchronous, active-high reset.
//     bus : mux_n_to_1_seq_if.slave. Carries the data, control and status signals.
//   SEL_WIDTH must equal ceil(log2(NUM_INPUTS)). NUM_INPUTS may range from 2 to 64.
//
//   Handshake: valid is a single-cycle strobe that marks a new sample on y.
//   There is no back-pressure in direct mode. In scan mode, hold acts as an
//   inverted ready. While hold is high, the scan index and y freeze and
//   valid stays low. The sample that was last presented is neither repeated
//   nor lost.
module mux_n_to_1_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic               clk,
  input  logic               rst,
  mux_n_to_1_seq_if.slave    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [SEL_WIDTH-1:0] LAST_IDX  = SEL_WIDTH'(NUM_INPUTS - 1);
  // One extra bit is needed so that the channel count fits even when
  // NUM_INPUTS is an exact power of two.
  localparam logic [SEL_WIDTH:0]   NUM_CHANS = (SEL_WIDTH + 1)'(NUM_INPUTS);

  state_t                state_q, state_n;
  logic [SEL_WIDTH-1:0]  idx_q, idx_n;
  logic [DATA_WIDTH-1:0] y_q, y_n;
  logic                  valid_q, valid_n;
  logic                  done_q, done_n;
  logic                  capture;
  logic                  sel_in_range;

  logic [DATA_WIDTH-1:0] chan [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] bank [NUM_INPUTS];

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_chan
    assign chan[k] = bus.d[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // A select value with no matching channel returns zero, not stale data.
  assign sel_in_range = ({1'b0, bus.s} < NUM_CHANS);

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    y_n     = y_q;
    valid_n = 1'b0;
    done_n  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mode) begin
          if (bus.start) begin
            capture = 1'b1;
            idx_n   = '0;
            state_n = SCAN;
          end
        end else if (bus.en) begin
          valid_n = 1'b1;
          y_n     = sel_in_range ? chan[bus.s] : '0;
        end
      end
      SCAN: begin
        if (!bus.hold) begin
          y_n     = bank[idx_q];
          valid_n = 1'b1;
          if (idx_q == LAST_IDX) begin
            // The last sample leaves SCAN in the same edge. The index
            // parks at 0, so bank[0] is never emitted a second time.
            done_n  = 1'b1;
            state_n = IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      y_q     <= y_n;
      valid_q <= valid_n;
      done_q  <= done_n;
    end
  end

  // The bank has no reset. It can only reach y from SCAN, and SCAN is
  // entered only through a capture, which rewrites every entry first.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        bank[k] <= chan[k];
      end
    end
  end

  assign bus.y         = y_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = (state_q == SCAN);
  assign bus.done      = done_q;
  assign bus.dbg_state = (state_q == SCAN);

endmodule

// File: tb/tb_mux_n_to_1_seq.sv
// tb_mux_n_to_1_seq
//   Self-checking bench for mux_n_to_1_seq with DATA_WIDTH=16 and NUM_INPUTS=8.
//   The reference model is transaction level. A scan appears as a queue of
//   pending samples (exp_q), and busy means that queue is not empty.
//   Inputs change on the falling edge, and outputs are checked on the
//   following falling edge.
module tb_mux_n_to_1_seq;
  localparam int DW = 16;
  localparam int NI = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_n_to_1_seq_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .SEL_WIDTH(SW)) bus ();

  mux_n_to_1_seq #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .SEL_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] exp_q[$];   // samples still owed by the current scan
  logic [DW-1:0] m_y;
  logic          m_valid;
  logic          m_done;

  int n_tests  = 0;
  int n_fail   = 0;
  int busy_cnt = 0;

  function automatic logic [DW-1:0] chan_of(input int k);
    return bus.d[k*DW +: DW];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_y     = '0;
    m_valid = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (exp_q.size() != 0) begin
      if (bus.hold) begin
        m_valid = 1'b0;
      end else begin
        m_y     = exp_q.pop_front();
        m_valid = 1'b1;
        m_done  = (exp_q.size() == 0);
      end
    end else if (bus.mode) begin
      m_valid = 1'b0;
      if (bus.start) begin
        for (int k = 0; k < NI; k++) exp_q.push_back(chan_of(k));
      end
    end else if (bus.en) begin
      m_valid = 1'b1;
      m_y     = (int'(bus.s) < NI) ? chan_of(int'(bus.s)) : '0;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (!rst) model_edge();
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check_val("y",     32'(bus.y),   32'(m_y));
    check_val("valid", 32'(bus.valid), 32'(m_valid));
    check_val("busy",  32'(bus.busy),  32'(exp_q.size() != 0));
    check_val("done",  32'(bus.done),  32'(m_done));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (bus.busy) busy_cnt++;
    check_outputs();
  endtask

  task automatic set_d_ramp(input int base);
    for (int k = 0; k < NI; k++) bus.d[k*DW +: DW] = 16'(base + k);
  endtask

  task automatic set_d_rand();
    for (int k = 0; k < NI; k++) bus.d[k*DW +: DW] = 16'($urandom_range(0, 65535));
  endtask

  task automatic idle_inputs();
    bus.mode  = 1'b0;
    bus.s     = '0;
    bus.en    = 1'b0;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
  endtask

  // Reset is applied between clock edges, so the outputs must clear at once.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_val({tag, "_y"},     32'(bus.y), 32'h0);
    check_val({tag, "_valid"}, 32'(bus.valid), 32'h0);
    check_val({tag, "_busy"},  32'(bus.busy),  32'h0);
    check_val({tag, "_done"},  32'(bus.done),  32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.d = '0;
    idle_inputs();
    model_reset();
    #2;
    check_val("reset_y",     32'(bus.y), 32'h0);
    check_val("reset_valid", 32'(bus.valid), 32'h0);
    check_val("reset_busy",  32'(bus.busy),  32'h0);
    check_val("reset_done",  32'(bus.done),  32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Direct select: stepping s over every channel.
    set_d_ramp(16'h1000);
    bus.en = 1'b1;
    for (int k = 0; k < NI; k++) begin
      bus.s = SW'(k);
      step();
      check_val("direct_y",     32'(bus.y), 32'(16'h1000 + k));
      check_val("direct_valid", 32'(bus.valid), 32'h1);
    end
    bus.en = 1'b0;
    bus.s  = SW'(2);
    step();
    check_val("en_low_hold_y", 32'(bus.y), 32'h1007);
    check_val("en_low_valid",  32'(bus.valid), 32'h0);

    // Plain scan. Changing d after the capture must have no effect.
    set_d_ramp(16'h00A0);
    bus.mode  = 1'b1;
    bus.start = 1'b1;
    busy_cnt  = 0;
    step();
    check_val("capture_valid", 32'(bus.valid), 32'h0);
    bus.start = 1'b0;
    bus.d     = '1;
    bus.mode  = 1'b0;  // ignored while scanning
    bus.en    = 1'b1;
    for (int k = 0; k < NI; k++) begin
      step();
      check_val("scan_y",    32'(bus.y), 32'(16'h00A0 + k));
      check_val("scan_done", 32'(bus.done), 32'(k == NI - 1));
    end
    check_val("scan_busy_cycles", 32'(busy_cnt), 32'd8);
    bus.mode = 1'b1;
    bus.en   = 1'b0;
    step();
    check_val("post_scan_y", 32'(bus.y), 32'h00A7);

    // A 3-cycle stall after sample A2.
    set_d_ramp(16'h00A0);
    bus.start = 1'b1;
    busy_cnt  = 0;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    bus.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("stall_y",     32'(bus.y), 32'h00A2);
      check_val("stall_valid", 32'(bus.valid), 32'h0);
    end
    bus.hold = 1'b0;
    for (int k = 3; k < NI; k++) begin
      step();
      check_val("post_stall_y", 32'(bus.y), 32'(16'h00A0 + k));
    end
    check_val("stall_busy_cycles", 32'(busy_cnt), 32'd11);

    // Reset mid-scan, after sample A4.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check_val("pre_reset_y", 32'(bus.y), 32'h00A4);
    async_reset("midscan_rst");
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("after_rst_valid", 32'(bus.valid), 32'h0);
    end

    // Back-to-back scans with start held high.
    bus.start = 1'b1;
    step();
    set_d_ramp(16'h00B0);
    for (int k = 0; k < NI; k++) step();
    check_val("b2b_first_done", 32'(bus.done), 32'h1);
    step();
    check_val("b2b_gap_valid", 32'(bus.valid), 32'h0);
    bus.start = 1'b0;
    for (int k = 0; k < NI; k++) begin
      step();
      check_val("b2b_second_y", 32'(bus.y), 32'(16'h00B0 + k));
    end
    set_d_ramp(16'h00C0);
    bus.mode = 1'b0;
    bus.en   = 1'b1;
    bus.s    = SW'(7);
    step();
    check_val("b2b_direct_s7", 32'(bus.y), 32'h00C7);

    // Randomized traffic checked against the model.
    for (int c = 0; c < 1500; c++) begin
      bus.mode  = 1'($urandom_range(0, 1));
      bus.start = ($urandom_range(0, 3) == 0);
      bus.hold  = ($urandom_range(0, 3) == 0);
      bus.en    = 1'($urandom_range(0, 1));
      bus.s     = SW'($urandom_range(0, NI - 1));
      set_d_rand();
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog, so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
